// File: rtl/qsys_gpio_scan_master.sv
// Avalon-MM master for the shield PIO: programs the OE register on enable, polls the
// pin register for masked changes (sticky IRQ) and forwards single host data writes.
module qsys_gpio_scan_master #(
  parameter logic [31:0] OE_INIT  = 32'h0000_0000,
  parameter logic [31:0] CHG_MASK = 32'h0FFF_FF3F,
  parameter int          PERIOD_W = 16
) (
  input  logic                csi_MCLK_clk,
  input  logic                rsi_MRST_reset,
  output logic [4:0]          avm_gpio_address,
  output logic [3:0]          avm_gpio_byteenable,
  output logic                avm_gpio_write,
  output logic                avm_gpio_read,
  output logic [31:0]         avm_gpio_writedata,
  input  logic [31:0]         avm_gpio_readdata,
  input  logic                avm_gpio_waitrequest,
  output logic                ins_INTRQ_irq,
  input  logic                coe_enable,
  input  logic [PERIOD_W-1:0] coe_period,
  input  logic                coe_wr_req,
  input  logic [31:0]         coe_wr_data,
  output logic                coe_wr_busy,
  output logic                coe_wr_ack,
  input  logic                coe_irq_clear,
  output logic [31:0]         coe_sample,
  output logic [31:0]         coe_change
);

  typedef enum logic [2:0] {
    IDLE,
    INIT_OE,
    WAIT,
    READ,
    WRITE
  } state_t;

  state_t              state_q;
  logic [PERIOD_W-1:0] cnt_q;
  logic [4:0]          addr_q;
  logic [3:0]          be_q;
  logic                write_q;
  logic                read_q;
  logic [31:0]         wdata_q;
  logic                wrPending_q;
  logic [31:0]         wrData_q;
  logic                wrAck_q;
  logic [31:0]         sample_q;
  logic [31:0]         change_q;
  logic                baseValid_q;

  logic [PERIOD_W-1:0] periodLoad;
  logic                readDone;
  logic [31:0]         chgSet;
  logic [31:0]         change_d;

  // Clear and a new change in the same cycle: the new bits survive the clear.
  always_comb begin
    periodLoad = (coe_period == '0) ? PERIOD_W'(1) : coe_period;
    readDone   = (state_q == READ) && read_q && !avm_gpio_waitrequest;
    chgSet     = baseValid_q ? ((avm_gpio_readdata ^ sample_q) & CHG_MASK) : 32'h0;
    change_d   = (coe_irq_clear ? 32'h0 : change_q) | (readDone ? chgSet : 32'h0);
  end

  always_ff @(posedge csi_MCLK_clk) begin
    if (rsi_MRST_reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= 5'd0;
      be_q        <= 4'h0;
      write_q     <= 1'b0;
      read_q      <= 1'b0;
      wdata_q     <= 32'h0;
      wrPending_q <= 1'b0;
      wrData_q    <= 32'h0;
      wrAck_q     <= 1'b0;
      sample_q    <= 32'h0;
      change_q    <= 32'h0;
      baseValid_q <= 1'b0;
    end else begin
      wrAck_q  <= 1'b0;
      change_q <= change_d;

      if (coe_wr_req && !wrPending_q) begin
        wrPending_q <= 1'b1;
        wrData_q    <= coe_wr_data;
      end

      case (state_q)
        IDLE: begin
          if (coe_enable) begin
            state_q     <= INIT_OE;
            addr_q      <= 5'd1;
            write_q     <= 1'b1;
            be_q        <= 4'hF;
            wdata_q     <= OE_INIT;
            baseValid_q <= 1'b0;
          end
        end

        INIT_OE: begin
          if (!avm_gpio_waitrequest) begin
            write_q <= 1'b0;
            be_q    <= 4'h0;
            if (coe_enable) begin
              state_q <= WAIT;
              cnt_q   <= periodLoad;
            end else begin
              state_q <= IDLE;
            end
          end
        end

        WAIT: begin
          if (!coe_enable) begin
            state_q <= IDLE;
          end else if (cnt_q <= PERIOD_W'(1)) begin
            addr_q <= 5'd0;
            be_q   <= 4'hF;
            if (wrPending_q) begin
              state_q <= WRITE;
              write_q <= 1'b1;
              wdata_q <= wrData_q;
            end else begin
              state_q <= READ;
              read_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - PERIOD_W'(1);
          end
        end

        // Arriving from WRITE the strobe is still low: issue the poll one cycle later.
        READ: begin
          if (!read_q) begin
            if (coe_enable) begin
              read_q <= 1'b1;
              be_q   <= 4'hF;
              addr_q <= 5'd0;
            end else begin
              state_q <= IDLE;
            end
          end else if (!avm_gpio_waitrequest) begin
            read_q      <= 1'b0;
            be_q        <= 4'h0;
            sample_q    <= avm_gpio_readdata;
            baseValid_q <= 1'b1;
            if (coe_enable) begin
              state_q <= WAIT;
              cnt_q   <= periodLoad;
            end else begin
              state_q <= IDLE;
            end
          end
        end

        WRITE: begin
          if (!avm_gpio_waitrequest) begin
            write_q     <= 1'b0;
            be_q        <= 4'h0;
            wrAck_q     <= 1'b1;
            wrPending_q <= 1'b0;
            state_q     <= coe_enable ? READ : IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign avm_gpio_address    = addr_q;
  assign avm_gpio_byteenable = be_q;
  assign avm_gpio_write      = write_q;
  assign avm_gpio_read       = read_q;
  assign avm_gpio_writedata  = wdata_q;
  assign ins_INTRQ_irq       = |change_q;
  assign coe_wr_busy         = wrPending_q;
  assign coe_wr_ack          = wrAck_q;
  assign coe_sample          = sample_q;
  assign coe_change          = change_q;

endmodule

// File: tb/tb_qsys_gpio_scan_master.sv
// Bench for qsys_gpio_scan_master: a stalling PIO slave model logs every accepted
// transfer, and each scenario task checks the log and the DUT outputs against spec rules.
module tb_qsys_gpio_scan_master;

  localparam logic [31:0] OE_INIT  = 32'h0000_003F;
  localparam logic [31:0] CHG_MASK = 32'h0FFF_FF3F;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  address;
  logic [3:0]  byteenable;
  logic        write;
  logic        read;
  logic [31:0] writedata;
  logic [31:0] rdata = 32'h0;
  logic        waitreq = 1'b0;
  logic        irq;
  logic        enable = 1'b0;
  logic [15:0] period = 16'd4;
  logic        wrReq = 1'b0;
  logic [31:0] wrData = 32'h0;
  logic        wrBusy;
  logic        wrAck;
  logic        irqClear = 1'b0;
  logic [31:0] sample;
  logic [31:0] change;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int stallCfg = 0;
  int stallLeft = 0;
  bit inXfer = 1'b0;
  bit prevStalled = 1'b0;
  logic [38:0] prevBus = '0;
  logic [31:0] rdQ[$];
  logic [31:0] rdDefault = 32'h0;
  bit          logWr[$];
  logic [4:0]  logAddr[$];
  logic [31:0] logData[$];
  int          logCyc[$];
  int          ackCyc[$];

  always #5 clk = ~clk;

  qsys_gpio_scan_master #(
    .OE_INIT (OE_INIT),
    .CHG_MASK(CHG_MASK),
    .PERIOD_W(16)
  ) dut (
    .csi_MCLK_clk        (clk),
    .rsi_MRST_reset      (reset),
    .avm_gpio_address    (address),
    .avm_gpio_byteenable (byteenable),
    .avm_gpio_write      (write),
    .avm_gpio_read       (read),
    .avm_gpio_writedata  (writedata),
    .avm_gpio_readdata   (rdata),
    .avm_gpio_waitrequest(waitreq),
    .ins_INTRQ_irq       (irq),
    .coe_enable          (enable),
    .coe_period          (period),
    .coe_wr_req          (wrReq),
    .coe_wr_data         (wrData),
    .coe_wr_busy         (wrBusy),
    .coe_wr_ack          (wrAck),
    .coe_irq_clear       (irqClear),
    .coe_sample          (sample),
    .coe_change          (change)
  );

  // Slave model: decides waitrequest for the coming edge, logs accepted transfers, checks bus rules.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      waitreq     = 1'b0;
      inXfer      = 1'b0;
      prevStalled = 1'b0;
    end else begin
      vectors++;
      if ((read && write) || (byteenable !== ((read || write) ? 4'hF : 4'h0))) begin
        miscompares++;
        $display("[TB] FAIL bus_rule: rd=%b wr=%b be=%h", read, write, byteenable);
      end
      if (prevStalled) begin
        vectors++;
        if ({read, write, address, writedata} !== prevBus) begin
          miscompares++;
          $display("[TB] FAIL bus_stable: got %h required %h", {read, write, address, writedata}, prevBus);
        end
      end
      if (read || write) begin
        if (!inXfer) begin
          inXfer    = 1'b1;
          stallLeft = stallCfg;
        end
        if (stallLeft > 0) begin
          stallLeft--;
          waitreq     = 1'b1;
          prevStalled = 1'b1;
          prevBus     = {read, write, address, writedata};
          rdata       = $urandom;
        end else begin
          waitreq     = 1'b0;
          prevStalled = 1'b0;
          inXfer      = 1'b0;
          if (read) begin
            if (rdQ.size() > 0) rdata = rdQ.pop_front();
            else rdata = rdDefault;
          end
          logWr.push_back(write);
          logAddr.push_back(address);
          logData.push_back(write ? writedata : rdata);
          logCyc.push_back(cyc);
        end
      end else begin
        waitreq     = 1'b0;
        inXfer      = 1'b0;
        prevStalled = 1'b0;
        rdata       = $urandom;
      end
      if (wrAck) ackCyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_log();
    logWr.delete();
    logAddr.delete();
    logData.delete();
    logCyc.delete();
    ackCyc.delete();
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    enable   = 1'b0;
    wrReq    = 1'b0;
    irqClear = 1'b0;
    stallCfg = 0;
    rdQ.delete();
    ticks(2);
    clear_log();
    reset = 1'b0;
    tick();
  endtask

  task automatic wait_log(input int n, input int bound, output bit ok);
    for (int i = 0; i < bound && logWr.size() < n; i++) tick();
    ok = (logWr.size() >= n);
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({write, read, byteenable, address} !== 11'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_strobes: got %h required 0", {write, read, byteenable, address});
    end
    vectors++;
    if (writedata !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_writedata: got %h required 0", writedata);
    end
    vectors++;
    if ({irq, wrBusy, wrAck} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: got %b required 000", {irq, wrBusy, wrAck});
    end
    vectors++;
    if (sample !== 32'h0 || change !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_sample_change: got %h/%h required 0/0", sample, change);
    end
  endtask

  task automatic test_init_oe();
    do_reset();
    period = 16'd4;
    enable = 1'b1;
    tick();
    vectors++;
    if ({write, read, address, byteenable, writedata} !== {1'b1, 1'b0, 5'd1, 4'hF, OE_INIT}) begin
      miscompares++;
      $display("[TB] FAIL init_oe_write: got wr=%b rd=%b a=%0d be=%h d=%h required wr@1 %h",
               write, read, address, byteenable, writedata, OE_INIT);
    end
    tick();
    vectors++;
    if (write !== 1'b0 || read !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL init_oe_to_wait: got wr=%b rd=%b required 0 0", write, read);
    end
    enable = 1'b0;
    ticks(10);
    vectors++;
    if (logWr.size() !== 1 || read !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL init_oe_only: got %0d transfers required 1", logWr.size());
    end
  endtask

  task automatic test_poll_period();
    bit ok;
    do_reset();
    period = 16'd4;
    rdQ.push_back(32'h5);
    rdQ.push_back(32'h7);
    rdDefault = 32'h7;
    enable = 1'b1;
    wait_log(3, 200, ok);
    tick();
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL poll_timeout: got %0d transfers required 3", logWr.size());
    end else begin
      vectors++;
      if (logWr[1] !== 1'b0 || logAddr[1] !== 5'd0 || logWr[2] !== 1'b0 || logAddr[2] !== 5'd0) begin
        miscompares++;
        $display("[TB] FAIL poll_reads: got wr=%b%b a=%0d/%0d required reads@0", logWr[1], logWr[2], logAddr[1], logAddr[2]);
      end
      vectors++;
      if (logCyc[1] - logCyc[0] !== 5 || logCyc[2] - logCyc[1] !== 5) begin
        miscompares++;
        $display("[TB] FAIL poll_spacing: got %0d/%0d required 5/5", logCyc[1] - logCyc[0], logCyc[2] - logCyc[1]);
      end
      vectors++;
      if (change !== 32'h2 || irq !== 1'b1 || sample !== 32'h7) begin
        miscompares++;
        $display("[TB] FAIL poll_change: got chg=%h irq=%b smp=%h required 2 1 7", change, irq, sample);
      end
    end
    enable = 1'b0;
    ticks(12);
  endtask

  task automatic test_baseline();
    bit ok;
    do_reset();
    period = 16'd2;
    rdDefault = 32'hFFFF_FFFF;
    enable = 1'b1;
    wait_log(3, 200, ok);
    tick();
    vectors++;
    if (!ok || change !== 32'h0 || sample !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("[TB] FAIL baseline_first: got n=%0d chg=%h smp=%h required 0 FFFFFFFF", logWr.size(), change, sample);
    end
    enable = 1'b0;
    ticks(20);
    vectors++;
    if (sample !== 32'hFFFF_FFFF || read !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL baseline_retained: got smp=%h rd=%b required FFFFFFFF 0", sample, read);
    end
    clear_log();
    rdDefault = 32'h0;
    enable = 1'b1;
    wait_log(2, 200, ok);
    tick();
    vectors++;
    if (!ok || change !== 32'h0 || sample !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL baseline_reenable: got n=%0d chg=%h smp=%h required 0 0", logWr.size(), change, sample);
    end
    enable = 1'b0;
    ticks(20);
  endtask

  task automatic test_stall();
    int n;
    int cnt;
    do_reset();
    period = 16'd2;
    stallCfg = 3;
    rdQ.push_back(32'h1234_5678);
    rdDefault = 32'h1234_5678;
    enable = 1'b1;
    n = 0;
    while (read !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    cnt = 0;
    while (read === 1'b1 && cnt < 20) begin
      vectors++;
      if (address !== 5'd0 || write !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL stall_addr: got a=%0d wr=%b required 0 0", address, write);
      end
      cnt++;
      tick();
    end
    vectors++;
    if (cnt !== 4) begin
      miscompares++;
      $display("[TB] FAIL stall_read_len: got %0d required 4", cnt);
    end
    vectors++;
    if (sample !== 32'h1234_5678) begin
      miscompares++;
      $display("[TB] FAIL stall_sample: got %h required 12345678", sample);
    end
    enable = 1'b0;
    ticks(20);
  endtask

  task automatic test_write_req();
    bit ok;
    int nw;
    do_reset();
    period = 16'd6;
    rdDefault = 32'h0;
    wrData = 32'h11;
    wrReq = 1'b1;
    tick();
    wrReq = 1'b0;
    ticks(3);
    vectors++;
    if (wrBusy !== 1'b1 || write !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL wr_idle_latch: got busy=%b wr=%b required 1 0", wrBusy, write);
    end
    enable = 1'b1;
    wait_log(3, 200, ok);
    vectors++;
    if (!ok || logWr[1] !== 1'b1 || logAddr[1] !== 5'd0 || logData[1] !== 32'h11 || logWr[2] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL wr_idle_sequence: got n=%0d second=%b@%0d %h required wr@0 11 then read",
               logWr.size(), logWr[1], logAddr[1], logData[1]);
    end
    wrData = 32'hA5;
    wrReq = 1'b1;
    tick();
    wrReq = 1'b0;
    vectors++;
    if (wrBusy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL wr_busy: got %b required 1", wrBusy);
    end
    tick();
    wrData = 32'h5A;
    wrReq = 1'b1;
    tick();
    wrReq = 1'b0;
    wait_log(5, 200, ok);
    ticks(30);
    nw = 0;
    foreach (logWr[i]) if (logWr[i] && logAddr[i] == 5'd0) nw++;
    vectors++;
    if (nw !== 2) begin
      miscompares++;
      $display("[TB] FAIL wr_count: got %0d data writes required 2", nw);
    end
    vectors++;
    if (!ok || logWr[3] !== 1'b1 || logData[3] !== 32'hA5 || logWr[4] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL wr_a5: got %b %h then wr=%b required wr A5 then read", logWr[3], logData[3], logWr[4]);
    end
    vectors++;
    if (ackCyc.size() !== 2) begin
      miscompares++;
      $display("[TB] FAIL wr_ack_count: got %0d required 2", ackCyc.size());
    end else begin
      vectors++;
      if (ackCyc[0] - logCyc[1] !== 1 || ackCyc[1] - logCyc[3] !== 1) begin
        miscompares++;
        $display("[TB] FAIL wr_ack_timing: got %0d/%0d required 1/1", ackCyc[0] - logCyc[1], ackCyc[1] - logCyc[3]);
      end
    end
    vectors++;
    if (wrBusy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL wr_busy_clear: got %b required 0", wrBusy);
    end
    enable = 1'b0;
    ticks(20);
  endtask

  task automatic test_irq_clear();
    bit ok;
    int n;
    do_reset();
    period = 16'd3;
    rdQ.push_back(32'h2);
    rdQ.push_back(32'h0);
    rdQ.push_back(32'h1);
    rdDefault = 32'h1;
    enable = 1'b1;
    wait_log(3, 200, ok);
    tick();
    vectors++;
    if (!ok || change !== 32'h2) begin
      miscompares++;
      $display("[TB] FAIL clr_pre: got chg=%h required 2", change);
    end
    n = 0;
    while (read !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    irqClear = 1'b1;
    tick();
    irqClear = 1'b0;
    vectors++;
    if (change !== 32'h1 || irq !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL clr_set_wins: got chg=%h irq=%b required 1 1", change, irq);
    end
    irqClear = 1'b1;
    tick();
    irqClear = 1'b0;
    vectors++;
    if (change !== 32'h0 || irq !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL clr_only: got chg=%h irq=%b required 0 0", change, irq);
    end
    enable = 1'b0;
    ticks(15);
  endtask

  task automatic test_reset_mid_write();
    bit ok;
    int n;
    do_reset();
    period = 16'd2;
    wrData = 32'h77;
    wrReq = 1'b1;
    tick();
    wrReq = 1'b0;
    enable = 1'b1;
    wait_log(1, 100, ok);
    stallCfg = 20;
    n = 0;
    while (!(write === 1'b1 && address === 5'd0) && n < 50) begin
      tick();
      n++;
    end
    ticks(2);
    reset = 1'b1;
    enable = 1'b0;
    tick();
    vectors++;
    if ({write, read, byteenable, wrBusy, wrAck} !== 8'h0) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_write: got wr=%b rd=%b be=%h busy=%b ack=%b required all 0",
               write, read, byteenable, wrBusy, wrAck);
    end
    reset = 1'b0;
    stallCfg = 0;
    ticks(3);
    vectors++;
    if (logWr.size() !== 1 || ackCyc.size() !== 0) begin
      miscompares++;
      $display("[TB] FAIL rst_no_completion: got %0d transfers %0d acks required 1 0", logWr.size(), ackCyc.size());
    end
  endtask

  task automatic test_random();
    bit ok;
    int pr;
    int pEff;
    int st;
    int nwr;
    logic [31:0] v;
    logic [31:0] expChange;
    for (int round = 0; round < 4; round++) begin
      do_reset();
      pr = $urandom_range(0, 5);
      pEff = (pr == 0) ? 1 : pr;
      st = $urandom_range(0, 2);
      period = 16'(pr);
      stallCfg = st;
      v = $urandom;
      for (int k = 0; k < 8; k++) begin
        if ($urandom_range(0, 2) != 0) v = v ^ (32'h1 << $urandom_range(0, 31));
        rdQ.push_back(v);
      end
      rdDefault = v;
      enable = 1'b1;
      wait_log(9, 400, ok);
      enable = 1'b0;
      ticks(40);
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("[TB] FAIL rnd_timeout: round %0d got %0d transfers required 9", round, logWr.size());
      end else begin
        nwr = 0;
        for (int i = 1; i < logWr.size(); i++) if (logWr[i] || logAddr[i] != 5'd0) nwr++;
        vectors++;
        if (nwr !== 0) begin
          miscompares++;
          $display("[TB] FAIL rnd_reads_only: round %0d got %0d non-poll transfers required 0", round, nwr);
        end
        for (int i = 1; i < 9; i++) begin
          vectors++;
          if (logCyc[i] - logCyc[i-1] !== pEff + 1 + st) begin
            miscompares++;
            $display("[TB] FAIL rnd_spacing: round %0d xfer %0d got %0d required %0d",
                     round, i, logCyc[i] - logCyc[i-1], pEff + 1 + st);
          end
        end
        expChange = 32'h0;
        for (int i = 2; i < logWr.size(); i++) expChange |= (logData[i] ^ logData[i-1]) & CHG_MASK;
        vectors++;
        if (change !== expChange || irq !== (|expChange)) begin
          miscompares++;
          $display("[TB] FAIL rnd_change: round %0d got %h irq=%b required %h", round, change, irq, expChange);
        end
        vectors++;
        if (sample !== logData[logData.size()-1]) begin
          miscompares++;
          $display("[TB] FAIL rnd_sample: round %0d got %h required %h", round, sample, logData[logData.size()-1]);
        end
        vectors++;
        if (read !== 1'b0 || write !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL rnd_idle: round %0d got rd=%b wr=%b required 0 0", round, read, write);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_init_oe();
    test_poll_period();
    test_baseline();
    test_stall();
    test_write_req();
    test_irq_clear();
    test_reset_mid_write();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
